// File: rtl/array_packer.sv
// array_packer: gathers WB-bit elements into a WA-element packed word.
// A word closes when it is full or when an accepted element carries s_last.
// Unused slots take FILL. The output register plus one held word in the
// assembly register give two words of buffering under output backpressure.
module array_packer #(
  parameter int              WA    = 8,
  parameter int              WB    = 8,
  parameter int              ORDER = 0,
  parameter logic [WB-1:0]   FILL  = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WB-1:0]               s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WA-1:0][WB-1:0]       m_data,
  output logic [$clog2(WA+1)-1:0]     m_cnt,
  output logic                        m_last
);

  localparam int CNT_W = $clog2(WA);
  localparam int MC_W  = $clog2(WA+1);

  localparam logic [0:0] STATE_COLLECT = 1'b0;
  localparam logic [0:0] STATE_HOLD    = 1'b1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WA-1);

  typedef logic [WA-1:0][WB-1:0] word_t;
  localparam word_t FILL_WORD = {WA{FILL}};

  // Element index to slot position, honouring the packing order.
  function automatic logic [CNT_W-1:0] slot_of(input logic [CNT_W-1:0] idx);
    if (ORDER != 0) return LAST_IDX - idx;
    else            return idx;
  endfunction

  // Number of supplied elements once element idx is added.
  function automatic logic [MC_W-1:0] count_of(input logic [CNT_W-1:0] idx);
    return MC_W'(idx) + MC_W'(1);
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            asm_q, asm_d;
  logic [MC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             hold_last_q, hold_last_d;
  word_t            out_data_q, out_data_d;
  logic [MC_W-1:0]  out_cnt_q, out_cnt_d;
  logic             out_last_q, out_last_d;
  logic             out_vld_q, out_vld_d;

  logic             accept;
  logic             closing;
  logic             out_free;
  word_t            merged;

  assign s_ready = (state_q == STATE_COLLECT);
  assign m_valid = out_vld_q;
  assign m_data  = out_data_q;
  assign m_cnt   = out_cnt_q;
  assign m_last  = out_last_q;

  // Handshake qualifiers and the word as it would look with the new element added.
  always_comb begin
    accept   = s_valid && s_ready;
    closing  = accept && ((cnt_q == LAST_IDX) || s_last);
    out_free = !out_vld_q || m_ready;
    merged   = asm_q;
    merged[slot_of(cnt_q)] = s_data;
  end

  // Next-state logic for the assembly FSM and the output register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    hold_cnt_d  = hold_cnt_q;
    hold_last_d = hold_last_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    out_vld_d   = out_vld_q;

    // A consumed word leaves the output unless replaced below.
    if (out_vld_q && m_ready) out_vld_d = 1'b0;

    case (state_q)
      STATE_COLLECT: begin
        if (accept && !closing) begin
          asm_d = merged;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (closing && out_free) begin
          out_data_d = merged;
          out_cnt_d  = count_of(cnt_q);
          out_last_d = s_last;
          out_vld_d  = 1'b1;
          asm_d      = FILL_WORD;
          cnt_d      = '0;
        end else if (closing) begin
          // Output busy: park the finished word until the output frees up.
          asm_d       = merged;
          hold_cnt_d  = count_of(cnt_q);
          hold_last_d = s_last;
          state_d     = STATE_HOLD;
        end
      end
      STATE_HOLD: begin
        if (out_free) begin
          out_data_d = asm_q;
          out_cnt_d  = hold_cnt_q;
          out_last_d = hold_last_q;
          out_vld_d  = 1'b1;
          asm_d      = FILL_WORD;
          cnt_d      = '0;
          state_d    = STATE_COLLECT;
        end
      end
      default: state_d = STATE_COLLECT;
    endcase
  end

  // State registers; reset discards any partial, held or pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STATE_COLLECT;
      cnt_q       <= '0;
      asm_q       <= FILL_WORD;
      hold_cnt_q  <= '0;
      hold_last_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      out_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_last_q <= hold_last_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      out_vld_q   <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_array_packer.sv
// Testbench for array_packer: two instances (ORDER=0/FILL=AA, ORDER=1/FILL=5C)
// share one input stream; a word-level queue model predicts their outputs.
module tb_array_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b0;

  logic        s_ready_a, s_ready_b, m_valid_a, m_valid_b, m_last_a, m_last_b;
  logic [63:0] m_data_a, m_data_b;
  logic [3:0]  m_cnt_a, m_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  array_packer #(.WA(8), .WB(8), .ORDER(0), .FILL(8'hAA)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_data(m_data_a), .m_cnt(m_cnt_a), .m_last(m_last_a));

  array_packer #(.WA(8), .WB(8), .ORDER(1), .FILL(8'h5C)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_data(m_data_b), .m_cnt(m_cnt_b), .m_last(m_last_b));

  // Reference model: elements of the word being gathered, and closed words
  // waiting to be consumed (the packer can buffer at most two).
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    int          cnt;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur[$];

  function automatic exp_t make_word(input logic last);
    exp_t w;
    for (int k = 0; k < 8; k++) begin
      w.a[8*k +: 8]     = (k < cur.size()) ? cur[k] : 8'hAA;
      w.b[8*(7-k) +: 8] = (k < cur.size()) ? cur[k] : 8'h5C;
    end
    w.cnt  = cur.size();
    w.last = last;
    return w;
  endfunction

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic tick();
    logic rdy;
    logic pop;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      cur.delete();
    end else begin
      rdy = exp_q.size() < 2;
      pop = (exp_q.size() > 0) && m_ready;
      if (pop) exp_q.delete(0);
      if (s_valid && rdy) begin
        cur.push_back(s_data);
        if (s_last || cur.size() == 8) begin
          exp_q.push_back(make_word(s_last));
          cur.delete();
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b/%b want 0", m_valid_a, m_valid_b); end
    checks++; if (m_data_a !== 64'h0 || m_data_b !== 64'h0) begin errors++; $display("FAIL reset_m_data got %h/%h want 0", m_data_a, m_data_b); end
    checks++; if (m_cnt_a !== 4'd0 || m_last_a !== 1'b0) begin errors++; $display("FAIL reset_cnt_last got %0d/%b want 0/0", m_cnt_a, m_last_a); end
    rst_n = 1'b1;
    tick();
    checks++; if (s_ready_a !== 1'b1 || s_ready_b !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b/%b want 1", s_ready_a, s_ready_b); end
  endtask

  task automatic test_full_word();
    idle(2);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 8'(i); s_last = 1'b0;
      tick();
      checks++; if (s_ready_a !== 1'b1) begin errors++; $display("FAIL full_s_ready elem %0d got %b want 1", i, s_ready_a); end
    end
    checks++; if (m_valid_a !== 1'b1) begin errors++; $display("FAIL full_m_valid got %b want 1", m_valid_a); end
    checks++; if (m_data_a !== 64'h0706050403020100) begin errors++; $display("FAIL full_order0 got %h want 0706050403020100", m_data_a); end
    checks++; if (m_data_b !== 64'h0001020304050607) begin errors++; $display("FAIL full_order1 got %h want 0001020304050607", m_data_b); end
    checks++; if (m_cnt_a !== 4'd8 || m_last_a !== 1'b0) begin errors++; $display("FAIL full_cnt_last got %0d/%b want 8/0", m_cnt_a, m_last_a); end
    s_valid = 1'b0;
    tick();
    checks++; if (m_valid_a !== 1'b0) begin errors++; $display("FAIL full_drain got %b want 0", m_valid_a); end
  endtask

  task automatic test_fill_last();
    logic [7:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = seq[i]; s_last = (i == 2);
      tick();
    end
    checks++; if (m_data_a !== 64'hAAAAAAAAAA332211) begin errors++; $display("FAIL last3_order0 got %h want AAAAAAAAAA332211", m_data_a); end
    checks++; if (m_data_b !== 64'h1122335C5C5C5C5C) begin errors++; $display("FAIL last3_order1 got %h want 1122335C5C5C5C5C", m_data_b); end
    checks++; if (m_cnt_a !== 4'd3 || m_last_a !== 1'b1) begin errors++; $display("FAIL last3_cnt_last got %0d/%b want 3/1", m_cnt_a, m_last_a); end
    s_data = 8'h44; s_last = 1'b1;
    tick();
    checks++; if (m_data_a !== 64'hAAAAAAAAAAAAAA44 || m_data_b !== 64'h445C5C5C5C5C5C5C) begin errors++; $display("FAIL single_data got %h/%h", m_data_a, m_data_b); end
    checks++; if (m_cnt_a !== 4'd1 || m_last_a !== 1'b1 || m_valid_a !== 1'b1) begin errors++; $display("FAIL single_cnt_last got %0d/%b want 1/1", m_cnt_a, m_last_a); end
    for (int i = 0; i < 8; i++) begin
      s_data = 8'(8'h80 + i); s_last = (i == 7);
      tick();
    end
    checks++; if (m_data_a !== 64'h8786858483828180 || m_cnt_a !== 4'd8 || m_last_a !== 1'b1) begin errors++; $display("FAIL last8 got %h cnt %0d last %b want 8786858483828180/8/1", m_data_a, m_cnt_a, m_last_a); end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_backpressure();
    idle(2);
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h10 + i); s_last = 1'b0;
      tick();
      if (i == 7) begin
        checks++; if (m_valid_a !== 1'b1 || m_data_a !== 64'h1716151413121110) begin errors++; $display("FAIL bp_first got %b %h want 1 1716151413121110", m_valid_a, m_data_a); end
      end
    end
    checks++; if (s_ready_a !== 1'b0 || s_ready_b !== 1'b0) begin errors++; $display("FAIL bp_hold_s_ready got %b/%b want 0", s_ready_a, s_ready_b); end
    s_data = 8'hEE; s_last = 1'b1;
    tick();
    checks++; if (m_data_a !== 64'h1716151413121110 || m_cnt_a !== 4'd8 || m_last_a !== 1'b0) begin errors++; $display("FAIL bp_stable got %h/%0d/%b", m_data_a, m_cnt_a, m_last_a); end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    tick();
    checks++; if (m_valid_a !== 1'b1 || m_data_a !== 64'h1F1E1D1C1B1A1918 || m_data_b !== 64'h18191A1B1C1D1E1F) begin errors++; $display("FAIL bp_second got %b %h %h", m_valid_a, m_data_a, m_data_b); end
    checks++; if (s_ready_a !== 1'b1) begin errors++; $display("FAIL bp_s_ready_back got %b want 1", s_ready_a); end
    tick();
    checks++; if (m_valid_a !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", m_valid_a); end
  endtask

  task automatic test_reset_mid();
    idle(2);
    m_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h30 + i); s_last = 1'b0;
      tick();
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++; if (m_valid_a !== 1'b0 || m_data_a !== 64'h0 || m_cnt_a !== 4'd0) begin errors++; $display("FAIL rstmid_async got %b %h %0d want 0", m_valid_a, m_data_a, m_cnt_a); end
    tick();
    rst_n = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hC0 + i); s_last = 1'b0;
      tick();
      if (i < 7) begin
        checks++; if (m_valid_a !== 1'b0) begin errors++; $display("FAIL rstmid_stale elem %0d got m_valid %b want 0", i, m_valid_a); end
      end
    end
    checks++; if (m_data_a !== 64'hC7C6C5C4C3C2C1C0 || m_cnt_a !== 4'd8 || m_valid_a !== 1'b1) begin errors++; $display("FAIL rstmid_word got %h cnt %0d want C7C6C5C4C3C2C1C0/8", m_data_a, m_cnt_a); end
    s_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    idle(2);
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1; s_data = 8'($urandom_range(0, 255)); s_last = 1'b0;
      tick();
      checks++; if (s_ready_a !== 1'b1) begin errors++; $display("FAIL b2b_s_ready elem %0d got %b want 1", i, s_ready_a); end
      checks++; if (m_valid_a !== (i % 8 == 7)) begin errors++; $display("FAIL b2b_m_valid elem %0d got %b want %b", i, m_valid_a, (i % 8 == 7)); end
      if (i % 8 == 7 && exp_q.size() > 0) begin
        checks++; if (m_data_a !== exp_q[0].a || m_data_b !== exp_q[0].b || m_cnt_a !== 4'd8) begin errors++; $display("FAIL b2b_word %0d got %h %h want %h %h", i / 8, m_data_a, m_data_b, exp_q[0].a, exp_q[0].b); end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_random();
    idle(2);
    for (int n = 0; n < 3000; n++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom_range(0, 255));
      s_last  = ($urandom_range(0, 4) == 0);
      m_ready = ($urandom_range(0, 1) == 1);
      tick();
      checks++; if (s_ready_a !== (exp_q.size() < 2) || s_ready_b !== (exp_q.size() < 2)) begin errors++; $display("FAIL rnd_s_ready cyc %0d got %b/%b want %b", n, s_ready_a, s_ready_b, exp_q.size() < 2); end
      checks++; if (m_valid_a !== (exp_q.size() > 0) || m_valid_b !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_m_valid cyc %0d got %b/%b want %b", n, m_valid_a, m_valid_b, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        checks++; if (m_data_a !== exp_q[0].a || m_data_b !== exp_q[0].b) begin errors++; $display("FAIL rnd_data cyc %0d got %h/%h want %h/%h", n, m_data_a, m_data_b, exp_q[0].a, exp_q[0].b); end
        checks++; if (m_cnt_a !== 4'(exp_q[0].cnt) || m_last_a !== exp_q[0].last || m_cnt_b !== 4'(exp_q[0].cnt) || m_last_b !== exp_q[0].last) begin errors++; $display("FAIL rnd_cnt_last cyc %0d got %0d/%b want %0d/%b", n, m_cnt_a, m_last_a, exp_q[0].cnt, exp_q[0].last); end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_fill_last();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_packer.md
ARRAY_PACKER -- requirements
Module: array_packer

Interface
REQ-001 SHALL have parameter WA, default 8: number of elements per packed output word, legal range 2..64.
REQ-002 SHALL have parameter WB, default 8: width in bits of one element, legal range 1..64.
REQ-003 SHALL have parameter ORDER, default 0: 0 places element k at m_data[k]; 1 places element k at m_data[WA-1-k].
REQ-004 SHALL have parameter FILL, WB bits, default all-zero: value written to element slots not supplied before s_last.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port s_valid  input  1  input element valid.
REQ-008 SHALL have port s_ready  output  1  input element accepted when s_valid && s_ready.
REQ-009 SHALL have port s_data  input  WB  input element.
REQ-010 SHALL have port s_last  input  1  accepted element closes the current word early.
REQ-011 SHALL have port m_valid  output  1  packed word valid.
REQ-012 SHALL have port m_ready  input  1  packed word consumed when m_valid && m_ready.
REQ-013 SHALL have port m_data  output  packed [WA-1:0][WB-1:0]  packed word.
REQ-014 SHALL have port m_cnt  output  $clog2(WA+1)  number of supplied elements in m_data, 1..WA.
REQ-015 SHALL have port m_last  output  1  word was closed by s_last (also set if s_last arrives on element WA-1).

Function
REQ-016 SHALL hold an assembly register (WA x WB), element counter cnt (0..WA-1) and output register (m_data, m_cnt, m_last, m_valid).
REQ-017 SHALL run an assembly FSM with states COLLECT and HOLD; s_ready = 1 in COLLECT, 0 in HOLD.
REQ-018 SHALL, in COLLECT on accept with cnt < WA-1 and s_last = 0, store s_data at slot per ORDER and increment cnt.
REQ-019 SHALL close the word on accept when cnt = WA-1 or s_last = 1; the closing word is the assembly contents plus the new element, remaining slots = FILL.
REQ-020 SHALL, on close, load the output register in the same edge if m_valid = 0 or (m_valid && m_ready), reset cnt to 0, refill assembly with FILL, stay in COLLECT.
REQ-021 SHALL, on close when the output register is occupied and not draining, store the word in the assembly register and enter HOLD.
REQ-022 SHALL, in HOLD, transfer assembly to output on the edge where m_valid = 0 or m_valid && m_ready, then reset cnt, refill FILL and return to COLLECT.
REQ-023 SHALL clear m_valid on m_valid && m_ready unless a new word is loaded in the same edge.
REQ-024 SHALL keep m_data, m_cnt, m_last stable while m_valid && !m_ready.
REQ-025 SHALL have latency: closing element accepted at edge t -> m_valid = 1 after edge t (visible in cycle t+1) when output free.
REQ-026 SHALL sustain one element per cycle with m_ready held 1 (no s_ready deassertion).
REQ-027 SHALL set m_cnt = cnt+1 of the closing element; m_cnt = WA for a full word.
REQ-028 SHALL treat s_last on a single-element word as valid: m_cnt = 1, WA-1 slots = FILL.
REQ-029 SHALL ignore s_data/s_last when s_valid = 0 or s_ready = 0.

Reset
REQ-030 SHALL, while rst_n = 0, force: FSM = COLLECT, cnt = 0, assembly = all FILL, m_valid = 0, m_data = 0, m_cnt = 0, m_last = 0; s_ready = 1 after release.
REQ-031 SHALL discard any partial or held word on reset assertion mid-operation; no word emitted for it after release.

Verification
REQ-032 SHALL check: WA=8, WB=8, ORDER=0, m_ready=1, stream 0x00..0x07 back-to-back -> one cycle after 8th accept m_data = 0x0706050403020100, m_cnt = 8, m_last = 0.
REQ-033 SHALL check: ORDER=1, same stream -> m_data = 0x0001020304050607.
REQ-034 SHALL check: FILL=0xAA, ORDER=0, elements 0x11,0x22,0x33 with s_last on 0x33 -> m_data = 0xAAAAAAAAAA332211, m_cnt = 3, m_last = 1.
REQ-035 SHALL check: m_ready=0, 16 elements offered -> first word in output, second in HOLD, s_ready = 0 after 16th accept; m_ready=1 for 2 cycles -> both words emitted in order, s_ready returns 1.
REQ-036 SHALL check: rst_n pulsed low after 5 accepted elements -> m_valid = 0, next 8 elements form a complete word with m_cnt = 8 and no trace of the earlier 5.
REQ-037 SHALL check: continuous 64 elements with m_ready=1 -> s_ready never drops, 8 words emitted at 8-cycle intervals.
